// File: rtl/kl8e_tty_ctl_if.sv
// kl8e_tty_ctl_if: CPU IOT bus, UART byte handshake and FSM debug taps for
// the KL8E console controller.
//
// Handshake: a request (tx_req / rx_req) is raised by the controller and held
// until the matching acknowledge (tx_ack / rx_ack) is sampled high at a
// rising clk edge; that edge completes the transfer and the request drops the
// following cycle. Received data (rx_data) is valid the cycle after rx_ack.
interface kl8e_tty_ctl_if;
  // CPU IOT bus
  logic       iot;
  logic [5:0] io_select;
  logic [2:0] io_op;
  logic [7:0] io_data_in;
  logic [7:0] io_data_out;
  logic       io_clear_ac;
  logic       io_skip;
  logic       int_req;
  // UART transmit side
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       tx_empty;
  // UART receive side
  logic       rx_req;
  logic       rx_ack;
  logic       rx_empty;
  logic [7:0] rx_data;
  // FSM state taps
  logic [1:0] dbg_rx_state;
  logic [1:0] dbg_tx_state;

  modport master (
    output iot, io_select, io_op, io_data_in,
    output tx_ack, tx_empty, rx_ack, rx_empty, rx_data,
    input  io_data_out, io_clear_ac, io_skip, int_req,
    input  tx_req, tx_data, rx_req,
    input  dbg_rx_state, dbg_tx_state
  );

  modport slave (
    input  iot, io_select, io_op, io_data_in,
    input  tx_ack, tx_empty, rx_ack, rx_empty, rx_data,
    output io_data_out, io_clear_ac, io_skip, int_req,
    output tx_req, tx_data, rx_req,
    output dbg_rx_state, dbg_tx_state
  );
endinterface

// File: rtl/kl8e_tty_ctl.sv
// kl8e_tty_ctl: KL8E-style console controller. Decodes keyboard (6'o03) and
// printer (6'o04) IOTs, keeps the keyboard/printer flags, fetches received
// bytes into kbd_buf and launches printer bytes from tx_buf.
// Optional feature macro KL8E_IE_EN: when defined, an interrupt-enable
// register (set by KIE) gates int_req; otherwise int_req is the OR of flags.
// FSM states are exposed on bus.dbg_rx_state / bus.dbg_tx_state.
module kl8e_tty_ctl (
  input logic            clk,
  input logic            reset,
  kl8e_tty_ctl_if.slave  bus
);
  localparam logic [5:0] KBD_DEV = 6'o03;
  localparam logic [5:0] TTO_DEV = 6'o04;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_CAP = 2'd2} rx_state_e;
  typedef enum logic [1:0] {T_IDLE = 2'd0, T_REQ = 2'd1, T_HOLD = 2'd2, T_BUSY = 2'd3} tx_state_e;

  rx_state_e  rx_state_q, rx_state_d;
  tx_state_e  tx_state_q, tx_state_d;
  logic       kbd_flag_q, kbd_flag_d;
  logic       tto_flag_q, tto_flag_d;
  logic [7:0] kbd_buf_q, kbd_buf_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       ie;

  // IOT decode: every op strobe is qualified by iot and the device code
  logic kbd_iot, tto_iot;
  logic op_kcf, op_ksf, op_kcc, op_krs, op_krb;
  logic op_tfl, op_tsf, op_tcf, op_tpc, op_tsk, op_tls;
  assign kbd_iot = bus.iot && (bus.io_select == KBD_DEV);
  assign tto_iot = bus.iot && (bus.io_select == TTO_DEV);
  assign op_kcf  = kbd_iot && (bus.io_op == 3'd0);
  assign op_ksf  = kbd_iot && (bus.io_op == 3'd1);
  assign op_kcc  = kbd_iot && (bus.io_op == 3'd2);
  assign op_krs  = kbd_iot && (bus.io_op == 3'd4);
  assign op_krb  = kbd_iot && (bus.io_op == 3'd6);
  assign op_tfl  = tto_iot && (bus.io_op == 3'd0);
  assign op_tsf  = tto_iot && (bus.io_op == 3'd1);
  assign op_tcf  = tto_iot && (bus.io_op == 3'd2);
  assign op_tpc  = tto_iot && (bus.io_op == 3'd4);
  assign op_tsk  = tto_iot && (bus.io_op == 3'd5);
  assign op_tls  = tto_iot && (bus.io_op == 3'd6);

  // FSM-derived events used by the datapath
  logic rx_cap, tx_load, tx_done;
  assign rx_cap  = (rx_state_q == R_CAP);
  assign tx_load = (op_tpc || op_tls) && (tx_state_q == T_IDLE);
  assign tx_done = (tx_state_q == T_BUSY) && bus.tx_empty;

  // State registers for both FSMs
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      tx_state_q <= T_IDLE;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
    end
  end

  // Receive next state: fetch only when a byte waits and the buffer is free
  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      R_IDLE:  if (!bus.rx_empty && !kbd_flag_q) rx_state_d = R_REQ;
      R_REQ:   if (bus.rx_ack) rx_state_d = R_CAP;
      R_CAP:   rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Transmit next state: T_HOLD keeps tx_empty unsampled right after the ack
  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      T_IDLE:  if (tx_load) tx_state_d = T_REQ;
      T_REQ:   if (bus.tx_ack) tx_state_d = T_HOLD;
      T_HOLD:  tx_state_d = T_BUSY;
      T_BUSY:  if (bus.tx_empty) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  // FSM outputs: requests are pure state decodes
  always_comb begin
    bus.rx_req       = (rx_state_q == R_REQ);
    bus.tx_req       = (tx_state_q == T_REQ);
    bus.dbg_rx_state = rx_state_q;
    bus.dbg_tx_state = tx_state_q;
  end

  // Flag and buffer next values; hardware set is applied last so it wins
  always_comb begin
    kbd_flag_d = kbd_flag_q;
    if (op_kcf || op_kcc || op_krb) kbd_flag_d = 1'b0;
    if (rx_cap)                     kbd_flag_d = 1'b1;
    tto_flag_d = tto_flag_q;
    if (op_tcf || op_tls)           tto_flag_d = 1'b0;
    if (op_tfl || tx_done)          tto_flag_d = 1'b1;
    kbd_buf_d = rx_cap  ? bus.rx_data    : kbd_buf_q;
    tx_buf_d  = tx_load ? bus.io_data_in : tx_buf_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_flag_q <= 1'b0;
      tto_flag_q <= 1'b0;
      kbd_buf_q  <= 8'h00;
      tx_buf_q   <= 8'h00;
    end else begin
      kbd_flag_q <= kbd_flag_d;
      tto_flag_q <= tto_flag_d;
      kbd_buf_q  <= kbd_buf_d;
      tx_buf_q   <= tx_buf_d;
    end
  end

`ifdef KL8E_IE_EN
  logic op_kie;
  logic ie_q, ie_d;
  assign op_kie = kbd_iot && (bus.io_op == 3'd5);

  // Interrupt enable next value, loaded from AC[0] by KIE
  always_comb begin
    ie_d = op_kie ? bus.io_data_in[0] : ie_q;
  end

  // Interrupt enable register, enabled out of reset
  always_ff @(posedge clk) begin
    if (reset) ie_q <= 1'b1;
    else       ie_q <= ie_d;
  end
  assign ie = ie_q;
`else
  assign ie = 1'b1;
`endif

  // CPU-side responses, combinational and only meaningful in the iot cycle
  always_comb begin
    bus.io_data_out = (op_krs || op_krb) ? kbd_buf_q : 8'h00;
    bus.io_clear_ac = op_kcc || op_krb;
    bus.io_skip     = (op_ksf && kbd_flag_q) || (op_tsf && tto_flag_q) ||
                      (op_tsk && (kbd_flag_q || tto_flag_q));
    bus.int_req     = ie && (kbd_flag_q || tto_flag_q);
    bus.tx_data     = tx_buf_q;
  end
endmodule

// File: tb/tb_kl8e_tty_ctl.sv
// tb_kl8e_tty_ctl: directed bench for kl8e_tty_ctl. Inputs change on the
// falling clk edge and outputs are sampled 1 time unit later.
module tb_kl8e_tty_ctl;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  kl8e_tty_ctl_if bus ();

  kl8e_tty_ctl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       iot;
    logic [5:0] sel;
    logic [2:0] op;
    logic [7:0] din;
    logic       skip;
    logic       clr;
    logic [7:0] dout;
    logic       irq;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input string name, input logic iot, input logic [5:0] sel,
                              input logic [2:0] op, input logic [7:0] din, input logic skip,
                              input logic clr, input logic [7:0] dout, input logic irq);
    vec_t v;
    v.name = name; v.iot = iot; v.sel = sel; v.op = op; v.din = din;
    v.skip = skip; v.clr = clr; v.dout = dout; v.irq = irq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_iot(input logic [5:0] sel, input logic [2:0] op, input logic [7:0] din);
    bus.iot = 1'b1; bus.io_select = sel; bus.io_op = op; bus.io_data_in = din;
  endtask

  task automatic idle_iot();
    bus.iot = 1'b0; bus.io_select = 6'o00; bus.io_op = 3'd0; bus.io_data_in = 8'h00;
  endtask

  logic [7:0] exp_q[$];
  int         bad;

  initial begin
    // Table: starting state kbd_flag=1, kbd_buf=0x53, tto_flag=0, ie=1
    vecs[0]  = mk("v_ksf_set",   1, 6'o03, 3'd1, 8'h00, 1, 0, 8'h00, 1);
    vecs[1]  = mk("v_tsf_clr",   1, 6'o04, 3'd1, 8'h00, 0, 0, 8'h00, 1);
    vecs[2]  = mk("v_tsk_kbd",   1, 6'o04, 3'd5, 8'h00, 1, 0, 8'h00, 1);
    vecs[3]  = mk("v_krs",       1, 6'o03, 3'd4, 8'h00, 0, 0, 8'h53, 1);
    vecs[4]  = mk("v_kbd_op3",   1, 6'o03, 3'd3, 8'hff, 0, 0, 8'h00, 1);
    vecs[5]  = mk("v_dev05",     1, 6'o05, 3'd1, 8'h00, 0, 0, 8'h00, 1);
    vecs[6]  = mk("v_tfl",       1, 6'o04, 3'd0, 8'h00, 0, 0, 8'h00, 1);
    vecs[7]  = mk("v_tsf_set",   1, 6'o04, 3'd1, 8'h00, 1, 0, 8'h00, 1);
    vecs[8]  = mk("v_tcf",       1, 6'o04, 3'd2, 8'h00, 0, 0, 8'h00, 1);
    vecs[9]  = mk("v_tsf_again", 1, 6'o04, 3'd1, 8'h00, 0, 0, 8'h00, 1);
    vecs[10] = mk("v_kcf",       1, 6'o03, 3'd0, 8'h00, 0, 0, 8'h00, 1);
    vecs[11] = mk("v_ksf_clr",   1, 6'o03, 3'd1, 8'h00, 0, 0, 8'h00, 0);
    vecs[12] = mk("v_tsk_none",  1, 6'o04, 3'd5, 8'h00, 0, 0, 8'h00, 0);
    vecs[13] = mk("v_krs_keep",  1, 6'o03, 3'd4, 8'h00, 0, 0, 8'h53, 0);
    vecs[14] = mk("v_no_strobe", 0, 6'o03, 3'd6, 8'h00, 0, 0, 8'h00, 0);
    vecs[15] = mk("v_kbd_op7",   1, 6'o03, 3'd7, 8'h00, 0, 0, 8'h00, 0);
    vecs[16] = mk("v_tto_op3",   1, 6'o04, 3'd3, 8'h00, 0, 0, 8'h00, 0);

    // Reset
    reset = 1'b1;
    idle_iot();
    bus.tx_ack = 1'b0; bus.tx_empty = 1'b1;
    bus.rx_ack = 1'b0; bus.rx_empty = 1'b1; bus.rx_data = 8'h00;
    repeat (2) cyc();
    #1;
    chk("rst_rx_req",   bus.rx_req, 0);
    chk("rst_tx_req",   bus.tx_req, 0);
    chk("rst_int_req",  bus.int_req, 0);
    chk("rst_tx_data",  bus.tx_data, 8'h00);
    chk("rst_rx_state", bus.dbg_rx_state, 0);
    chk("rst_tx_state", bus.dbg_tx_state, 0);

    // Release reset with a byte waiting; KRS shows the cleared kbd_buf
    cyc();
    reset = 1'b0; bus.rx_empty = 1'b0;
    drive_iot(6'o03, 3'd4, 8'h00);
    #1 chk("rst_kbd_buf", bus.io_data_out, 8'h00);
    cyc(); idle_iot();
    #1 chk("rx1_req", bus.rx_req, 1);
    bus.rx_ack = 1'b1;
    cyc(); bus.rx_ack = 1'b0; bus.rx_data = 8'h53; bus.rx_empty = 1'b1;
    #1 chk("rx1_cap_state", bus.dbg_rx_state, 2);
    chk("rx1_req_drop", bus.rx_req, 0);
    chk("rx1_flag_late", bus.int_req, 0);
    cyc();
    #1 chk("rx1_flag_set", bus.int_req, 1);

    // IOT decode table
    for (int i = 0; i < 17; i++) begin
      cyc();
      bus.iot = vecs[i].iot; bus.io_select = vecs[i].sel;
      bus.io_op = vecs[i].op; bus.io_data_in = vecs[i].din;
      #1;
      chk({vecs[i].name, "_skip"}, bus.io_skip, vecs[i].skip);
      chk({vecs[i].name, "_clr"},  bus.io_clear_ac, vecs[i].clr);
      chk({vecs[i].name, "_dout"}, bus.io_data_out, vecs[i].dout);
      chk({vecs[i].name, "_irq"},  bus.int_req, vecs[i].irq);
    end
    cyc(); idle_iot();

    // Fetch 0x61, then 0x54 stays pending while kbd_flag blocks
    bus.rx_empty = 1'b0;
    cyc();
    #1 chk("rx2_req", bus.rx_req, 1);
    bus.rx_ack = 1'b1;
    cyc(); bus.rx_ack = 1'b0; bus.rx_data = 8'h61;
    exp_q.push_back(8'h61);
    #1 chk("rx2_cap_state", bus.dbg_rx_state, 2);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.rx_data = 8'h54;
      #1 if (bus.rx_req !== 1'b0) bad++;
    end
    chk("rx_blocked_by_flag", bad, 0);
    cyc(); drive_iot(6'o03, 3'd6, 8'h00);
    #1 chk("krb_dout", bus.io_data_out, exp_q.pop_front());
    chk("krb_clr", bus.io_clear_ac, 1);
    cyc(); idle_iot();
    #1 chk("krb_flag_clr", bus.int_req, 0);
    chk("krb_rx_req_wait", bus.rx_req, 0);
    cyc();
    #1 chk("rx3_req", bus.rx_req, 1);
    bus.rx_ack = 1'b1;

    // KCF in the R_CAP cycle: set wins, byte retained
    cyc(); bus.rx_ack = 1'b0; bus.rx_data = 8'h54; bus.rx_empty = 1'b1;
    exp_q.push_back(8'h54);
    drive_iot(6'o03, 3'd0, 8'h00);
    #1 chk("kcf_cap_state", bus.dbg_rx_state, 2);
    cyc(); drive_iot(6'o03, 3'd1, 8'h00);
    #1 chk("kcf_cap_flag", bus.io_skip, 1);
    cyc(); drive_iot(6'o03, 3'd4, 8'h00);
    #1 chk("kcf_cap_buf", bus.io_data_out, exp_q.pop_front());

    // Transmit 0x41 via TLS
    cyc(); drive_iot(6'o04, 3'd6, 8'h41);
    #1 chk("tls_skip", bus.io_skip, 0);
    cyc(); idle_iot();
    #1 chk("tx_req_rise", bus.tx_req, 1);
    chk("tx_data", bus.tx_data, 8'h41);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1 if (bus.tx_req !== 1'b1) bad++;
    end
    chk("tx_req_held", bad, 0);
    bus.tx_ack = 1'b1; bus.tx_empty = 1'b0;
    cyc(); bus.tx_ack = 1'b0;
    #1 chk("tx_hold_req", bus.tx_req, 0);
    chk("tx_hold_state", bus.dbg_tx_state, 2);
    drive_iot(6'o04, 3'd0, 8'h00);
    cyc(); drive_iot(6'o04, 3'd1, 8'h00);
    #1 chk("tfl_busy_skip", bus.io_skip, 1);
    // TLS 0x42 while busy: ignored for tx_buf, still clears tto_flag
    cyc(); drive_iot(6'o04, 3'd6, 8'h42);
    #1 chk("tls_busy_state", bus.dbg_tx_state, 3);
    cyc(); drive_iot(6'o04, 3'd1, 8'h00);
    #1 chk("tls_busy_tto_clr", bus.io_skip, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(); idle_iot();
      #1 if (bus.tx_req !== 1'b0 || bus.tx_data !== 8'h41) bad++;
    end
    chk("tx_busy_quiet", bad, 0);
    // Completion edge coincides with TCF: set wins
    cyc(); bus.tx_empty = 1'b1; drive_iot(6'o04, 3'd2, 8'h00);
    #1 chk("tx_done_state", bus.dbg_tx_state, 3);
    cyc(); drive_iot(6'o04, 3'd1, 8'h00);
    #1 chk("tx_done_tsf", bus.io_skip, 1);
    chk("tx_idle_state", bus.dbg_tx_state, 0);

    // KIE with AC[0]=0 and both flags set
    cyc(); drive_iot(6'o03, 3'd5, 8'h00);
    cyc(); idle_iot();
`ifdef KL8E_IE_EN
    #1 chk("kie_off_irq", bus.int_req, 0);
`else
    #1 chk("kie_off_irq", bus.int_req, 1);
`endif
    cyc(); drive_iot(6'o03, 3'd5, 8'h01);
    cyc(); idle_iot();
    #1 chk("kie_on_irq", bus.int_req, 1);

    // KCC, start a new fetch and a new transmit, then reset mid-handshake
    cyc(); drive_iot(6'o03, 3'd2, 8'h00); bus.rx_empty = 1'b0;
    #1 chk("kcc_clr", bus.io_clear_ac, 1);
    chk("kcc_dout", bus.io_data_out, 8'h00);
    cyc(); idle_iot();
    cyc(); drive_iot(6'o04, 3'd6, 8'h77);
    #1 chk("rx4_req", bus.rx_req, 1);
    cyc(); idle_iot(); bus.rx_empty = 1'b1; reset = 1'b1;
    #1 chk("tx4_req", bus.tx_req, 1);
    cyc(); reset = 1'b0;
    #1 chk("rst2_rx_req", bus.rx_req, 0);
    chk("rst2_tx_req", bus.tx_req, 0);
    chk("rst2_int_req", bus.int_req, 0);
    chk("rst2_tx_data", bus.tx_data, 8'h00);
    cyc(); drive_iot(6'o03, 3'd4, 8'h00);
    #1 chk("rst2_kbd_buf", bus.io_data_out, 8'h00);
    cyc(); idle_iot();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/kl8e_tty_ctl.md
# kl8e_tty_ctl

KL8E-style console controller that sits between the CPU IOT bus and the byte-wide UART handshake (tx_req/tx_ack/tx_empty, rx_req/rx_ack/rx_empty/rx_data). It sequences the UART by fetching received characters into a keyboard buffer and launching printer characters. It also keeps the keyboard and printer flags, decodes the keyboard and printer IOTs, and drives skip, AC clear, read data and the interrupt request back to the CPU.

## Interface
- KBD_DEV, 6'o03, keyboard device code.
- TTO_DEV, 6'o04, printer device code.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- iot  in  1  one-cycle IOT strobe
- io_select  in  6  device code, MB[8:3]
- io_op  in  3  IOT op bits, MB[2:0]
- io_data_in  in  8  AC[7:0]
- io_data_out  out  8  data ORed into AC. Equals kbd_buf on a read op, otherwise 0.
- io_clear_ac  out  1  clear AC this IOT
- io_skip  out  1  skip this IOT
- int_req  out  1  interrupt request
- tx_req  out  1  UART transmit request
- tx_data  out  8  transmit byte, equals tx_buf
- tx_ack  in  1  UART accepted byte
- tx_empty  in  1  UART transmitter idle
- rx_req  out  1  UART receive request
- rx_ack  in  1  UART receive acknowledge
- rx_empty  in  1  no character available
- rx_data  in  8  received byte, valid the cycle after rx_ack

## Operation
- Decoded IOTs (io_select/io_op):
  - KCF, KBD op 0: clear kbd_flag.
  - KSF, op 1: skip if kbd_flag.
  - KCC, op 2: clear AC and kbd_flag.
  - KRS, op 4: read kbd_buf.
  - KIE, op 5: ie <= io_data_in[0].
  - KRB, op 6: clear AC, read kbd_buf, clear kbd_flag.
  - TFL, TTO op 0: set tto_flag.
  - TSF, op 1: skip if tto_flag.
  - TCF, op 2: clear tto_flag.
  - TPC, op 4: load tx_buf and start.
  - TSK, op 5: skip if kbd_flag or tto_flag.
  - TLS, op 6: clear tto_flag, load tx_buf and start.
  - Other ops and other device codes produce no action, and all outputs stay 0.
- Receive FSM:
  - R_IDLE → R_REQ when !rx_empty && !kbd_flag.
  - R_REQ: rx_req=1. → R_CAP on rx_ack.
  - R_CAP: rx_req=0. kbd_buf <= rx_data, kbd_flag <= 1. → R_IDLE.
- Transmit FSM:
  - T_IDLE: a TPC/TLS loads tx_buf <= io_data_in → T_REQ.
  - T_REQ: tx_req=1. → T_HOLD on tx_ack.
  - T_HOLD: one cycle, tx_req=0. → T_BUSY.
  - T_BUSY: on tx_empty, tto_flag <= 1 → T_IDLE.
- TPC/TLS while not in T_IDLE: tx_buf and the FSM are unchanged. TLS still clears tto_flag.
- int_req = ie && (kbd_flag || tto_flag).

## Timing
- IOT responses (io_skip, io_clear_ac, io_data_out) are combinational, valid only in the iot cycle.
- Flag, ie and tx_buf updates take effect at the clock edge ending the iot cycle.
- Receive latency: rx_empty falling with kbd_flag clear → rx_req the next cycle. rx_ack → kbd_flag set 2 edges later.
- The cycle after KRB/KCC clears the flag, R_IDLE may start the next fetch.
- Transmit: TLS edge → tx_req the next cycle. It stays high until tx_ack is sampled.
  - T_HOLD guarantees tx_empty is not sampled in the ack cycle or the one after it.
- Simultaneous events:
  - Set wins over clear on the same flag (KCF during R_CAP; TCF in the edge T_BUSY completes).
  - KRS/KRB in the R_CAP cycle returns the old kbd_buf.
- Reset values:
  - States R_IDLE and T_IDLE.
  - kbd_flag=0, tto_flag=0, ie=1, kbd_buf=0, tx_buf=0.
  - tx_req=0, rx_req=0, int_req=0.
- Reset mid-handshake drops the transaction. A partly received character is lost.

## Configuration
- KL8E_IE_EN defined:
  - ie register and KIE decode are present.
  - int_req follows the formula above.
- KL8E_IE_EN undefined:
  - No ie register, and KIE is a no-op.
  - int_req = kbd_flag || tto_flag.

## Test plan
- Reset, then UART presents 0x53 (rx_empty=0): rx_req rises 1 cycle after reset release. kbd_flag=1 two edges after rx_ack. KSF skips. KRB returns io_data_out=0x53 with io_clear_ac=1, and the flag clears.
- With kbd_flag set and a second byte 0x54 pending: no rx_req until KRB. After KRB, rx_req rises the next cycle.
- TLS with AC=0x41: tx_data=0x41, tx_req held until tx_ack. tto_flag=0 until tx_empty returns (about 20 cycles with the fake UART), then tto_flag=1 and TSF skips.
- TLS 0x42 issued while T_BUSY: tx_data stays 0x41 and no second tx_req occurs. tto_flag=0 after the TLS, then set on completion.
- KCF in the R_CAP cycle: kbd_flag ends at 1 and the byte is retained.
- KIE with AC[0]=0 and both flags set: int_req=0 when KL8E_IE_EN is defined, int_req=1 when it is undefined.
